// File: rtl/pc_gen_ras.sv
// -----------------------------------------------------------------------------
// pc_gen_ras
//   Fetch-stage program counter with a circular return-address stack (RAS).
//   Every cycle one next-PC candidate is chosen. Highest priority first:
//     absolute redirect, RAS pop (only when the stack is non-empty),
//     PC-relative branch, sequential step.
//   The chosen candidate has its low ALIGN_BITS forced to zero. A call
//   pushes pc+STEP onto the RAS. When the stack is full, a push overwrites
//   the oldest entry.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   Defined   : a misaligned candidate with en=1 freezes pc and the RAS.
//               misalign_trap is then high for exactly the following cycle.
//   Undefined : misaligned LSBs are silently cleared.
//               misalign_trap is tied to 0.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   en               advance PC / apply RAS op; 0 = stall
//   redirect_valid   absolute redirect request, target on redirect_target
//   br_taken         PC-relative redirect, signed offset on imm_val
//   call / ret       push pc+STEP / pop RAS top as target
//   pc               registered current PC
//   pc_next          combinational next PC (aligned)
//   pc_plus_step     combinational pc + STEP
//   ras_empty        RAS holds no entries
//   ras_full         RAS holds RAS_DEPTH entries
//   misalign_trap    registered misalignment pulse (feature build only)
// -----------------------------------------------------------------------------
module pc_gen_ras #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              STEP         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            br_taken,
  input  logic [XLEN-1:0] imm_val,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_plus_step,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign_trap
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Bits that must be zero in an aligned PC.
  localparam logic [XLEN-1:0] ALIGN_LOW = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  ras_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [CNT_W-1:0] count_r;

  logic [XLEN-1:0]  step_s;
  logic [XLEN-1:0]  cand_s;
  logic [XLEN-1:0]  next_s;
  logic             empty_s;
  logic             full_s;
  logic             ret_hit_s;
  logic             update_s;
  logic [PTR_W-1:0] top_inc_s;
  logic [PTR_W-1:0] top_dec_s;

  assign step_s    = pc_r + XLEN'(STEP);
  assign empty_s   = (count_r == CNT_W'(0));
  assign full_s    = (count_r == CNT_W'(RAS_DEPTH));
  assign ret_hit_s = ret & ~empty_s;
  // The pointers wrap naturally because RAS_DEPTH is a power of two.
  assign top_inc_s = top_r + PTR_W'(1);
  assign top_dec_s = top_r - PTR_W'(1);

  // Next-PC candidate selection in priority order.
  always_comb begin
    cand_s = step_s;
    if (redirect_valid) begin
      cand_s = redirect_target;
    end else if (ret_hit_s) begin
      cand_s = ras_r[top_r];
    end else if (br_taken) begin
      cand_s = pc_r + imm_val;
    end else begin
      cand_s = step_s;
    end
  end

  assign next_s = cand_s & ~ALIGN_LOW;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_s;
  logic misalign_trap_r;

  assign misalign_s = |(cand_s & ALIGN_LOW);
  // A misaligned target blocks both the PC update and the RAS operation.
  assign update_s   = en & ~misalign_s;

  // One-cycle registered trap pulse for a misaligned, enabled fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_trap_r <= 1'b0;
    end else begin
      misalign_trap_r <= en & misalign_s;
    end
  end

  assign misalign_trap = misalign_trap_r;
`else
  assign update_s      = en;
  assign misalign_trap = 1'b0;
`endif

  // PC register and circular RAS. Reset wipes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_VECTOR;
      top_r   <= '0;
      count_r <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= '0;
      end
    end else if (update_s) begin
      pc_r <= next_s;
      case ({call, ret_hit_s})
        // Call and pop together: replace the top in place; depth is unchanged.
        2'b11: begin
          ras_r[top_r] <= step_s;
        end
        // Push. When full, the oldest slot is overwritten and count saturates.
        2'b10: begin
          ras_r[top_inc_s] <= step_s;
          top_r            <= top_inc_s;
          if (!full_s) begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        2'b01: begin
          top_r   <= top_dec_s;
          count_r <= count_r - CNT_W'(1);
        end
        default: begin
          top_r <= top_r;
        end
      endcase
    end
  end

  assign pc           = pc_r;
  assign pc_next      = next_s;
  assign pc_plus_step = step_s;
  assign ras_empty    = empty_s;
  assign ras_full     = full_s;

endmodule

// File: tb/tb_pc_gen_ras.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_ras
//   Self-checking bench for pc_gen_ras with RESET_VECTOR=0x100, RAS_DEPTH=4,
//   ALIGN_BITS=2 and STEP=4.
//   The reference model keeps the RAS as a bounded queue:
//     - a push beyond four entries drops the front;
//     - a pop takes the back.
// -----------------------------------------------------------------------------
module tb_pc_gen_ras;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        br_taken;
  logic [31:0] imm_val;
  logic        call;
  logic        ret;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus_step;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign_trap;

  pc_gen_ras #(
    .XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(4), .ALIGN_BITS(2), .STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .br_taken(br_taken), .imm_val(imm_val), .call(call), .ret(ret),
    .pc(pc), .pc_next(pc_next), .pc_plus_step(pc_plus_step),
    .ras_empty(ras_empty), .ras_full(ras_full), .misalign_trap(misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_trap;

  typedef struct {
    bit          e;
    bit          rv;
    logic [31:0] rt;
    bit          br;
    logic [31:0] imm;
    bit          c;
    bit          r;
    logic [31:0] exp_pc;
    bit          exp_empty;
    bit          exp_full;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit e, bit rv, logic [31:0] rt, bit br, logic [31:0] imm,
                              bit c, bit r, logic [31:0] xp, bit xe, bit xf);
    vec_t v;
    v.e = e; v.rv = rv; v.rt = rt; v.br = br; v.imm = imm; v.c = c; v.r = r;
    v.exp_pc = xp; v.exp_empty = xe; v.exp_full = xf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RV;
    m_ras.delete();
    m_trap = 1'b0;
  endtask

  // Called at posedge+1: drive inputs, check the combinational outputs at the
  // falling edge, then cross the rising edge and check the registered state.
  task automatic step(input bit e, input bit rv, input logic [31:0] rt, input bit br,
                      input logic [31:0] imm, input bit c, input bit r);
    int          sz;
    bit          rh;
    bit          mis;
    bit          upd;
    logic [31:0] cand;
    logic [31:0] nx;
    logic [31:0] ra;
    en = e; redirect_valid = rv; redirect_target = rt; br_taken = br;
    imm_val = imm; call = c; ret = r;
    sz = m_ras.size();
    rh = r && (sz > 0);
    if (rv)      cand = rt;
    else if (rh) cand = m_ras[sz-1];
    else if (br) cand = m_pc + imm;
    else         cand = m_pc + 32'd4;
    nx  = {cand[31:2], 2'b00};
    mis = (cand[1:0] != 2'b00);
    upd = e && !(TRAP && mis);
    #4;
    chk("pc_next", pc_next, nx);
    chk("pc_plus_step", pc_plus_step, m_pc + 32'd4);
    @(posedge clk);
    #1;
    if (upd) begin
      ra = m_pc + 32'd4;
      if (c && rh) begin
        m_ras[sz-1] = ra;
      end else if (c) begin
        m_ras.push_back(ra);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (rh) begin
        void'(m_ras.pop_back());
      end
      m_pc = nx;
    end
    m_trap = TRAP && e && mis;
    chk("pc", pc, m_pc);
    chk("ras_empty", {31'd0, ras_empty}, {31'd0, (m_ras.size() == 0)});
    chk("ras_full", {31'd0, ras_full}, {31'd0, (m_ras.size() == 4)});
    chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] rt;
    logic [31:0] imm;

    rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    br_taken = 1'b0; imm_val = 32'd0; call = 1'b0; ret = 1'b0;
    model_reset();
    #12;
    chk("reset_pc", pc, 32'h0000_0100);
    chk("reset_empty", {31'd0, ras_empty}, 32'd1);
    chk("reset_full", {31'd0, ras_full}, 32'd0);
    chk("reset_trap", {31'd0, misalign_trap}, 32'd0);
    chk("reset_pc_next", pc_next, 32'h0000_0104);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential steps, branches, redirects, calls/returns, RAS overflow,
    // stalls, call+ret in one cycle, and address wrap.
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h104,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h108,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h10C,1,0));
    tbl.push_back(mk(1,1,32'h200,0,0,0,0, 32'h200,1,0));
    tbl.push_back(mk(1,0,0,1,32'hFFFF_FFF8,0,0, 32'h1F8,1,0));
    tbl.push_back(mk(1,1,32'h3000,1,32'hFFFF_FFF8,0,0, 32'h3000,1,0));
    tbl.push_back(mk(1,1,32'h40,0,0,0,0, 32'h40,1,0));
    tbl.push_back(mk(1,1,32'h800,0,0,1,0, 32'h800,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h44,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,0, 32'h48,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0, 32'h4C,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0, 32'h50,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0, 32'h54,0,1));
    tbl.push_back(mk(1,0,0,0,0,1,0, 32'h58,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h58,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h54,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h50,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h4C,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h50,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,0, 32'h54,0,0));
    tbl.push_back(mk(0,0,0,1,32'h100,1,1, 32'h54,0,0));
    tbl.push_back(mk(0,0,0,1,32'h100,1,1, 32'h54,0,0));
    tbl.push_back(mk(0,0,0,1,32'h100,1,1, 32'h54,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h54,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,0, 32'h58,0,0));
    tbl.push_back(mk(1,1,32'h600,0,0,0,0, 32'h600,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,1, 32'h58,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h604,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,1, 32'h608,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 32'h608,1,0));
    tbl.push_back(mk(1,1,32'hFFFF_FFFC,0,0,0,0, 32'hFFFF_FFFC,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h0,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].e, tbl[i].rv, tbl[i].rt, tbl[i].br, tbl[i].imm, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_empty", i), {31'd0, ras_empty}, {31'd0, tbl[i].exp_empty});
      chk($sformatf("tbl%0d_full", i), {31'd0, ras_full}, {31'd0, tbl[i].exp_full});
    end

    // Misaligned redirect: the feature build holds pc and pulses the trap;
    // the default build clears the LSBs.
    held = m_pc;
    step(1, 1, 32'h1002, 0, 0, 1, 0);
    chk("misalign_pc", pc, TRAP ? held : 32'h1000);
    chk("misalign_pulse", {31'd0, misalign_trap}, {31'd0, TRAP});
    step(0, 0, 0, 0, 0, 0, 0);
    chk("misalign_pulse_end", {31'd0, misalign_trap}, 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rt = $urandom;
      if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) imm = $urandom;
      else imm = ($urandom_range(0, 255) * 4) - 512;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, rt,
           $urandom_range(0, 3) == 0, imm,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset between clock edges takes effect immediately.
    #2;
    en = 1'b0; call = 1'b0; ret = 1'b0; redirect_valid = 1'b0; br_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0000_0100);
    chk("async_rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("async_rst_trap", {31'd0, misalign_trap}, 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 1);
    chk("post_rst_ret_noop", pc, 32'h0000_0104);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("post_rst_ret", pc, 32'h0000_0108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
